// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the 8sc instruction fetch front end: field widths,
// opcode encodings (matching control_unit) and the fetch FSM state type.
package fetch_pkg;

    localparam int OPC_W = 3;
    localparam int OPR_W = 5;

    localparam logic [OPC_W-1:0] OP_0 = 3'd0;
    localparam logic [OPC_W-1:0] OP_1 = 3'd1;
    localparam logic [OPC_W-1:0] OP_2 = 3'd2;
    localparam logic [OPC_W-1:0] OP_3 = 3'd3;
    localparam logic [OPC_W-1:0] OP_4 = 3'd4;
    localparam logic [OPC_W-1:0] OP_5 = 3'd5;
    localparam logic [OPC_W-1:0] OP_6 = 3'd6;
    localparam logic [OPC_W-1:0] OP_7 = 3'd7;

    localparam logic [OPC_W-1:0] OP_BRANCH = OP_3;
    localparam logic [OPC_W-1:0] OP_STORE  = OP_5;
    localparam logic [OPC_W-1:0] OP_LDH    = OP_7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ISSUE = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction issue channel between the fetch unit (master) and
// decode/execute in control_unit (slave).
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int OPC_W  = 3,
    parameter int OPR_W  = 5
);
    logic              instr_valid;
    logic              instr_ready;
    logic [OPC_W-1:0]  instr_opcode;
    logic [OPR_W-1:0]  instr_operand;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output instr_valid,
        output instr_opcode,
        output instr_operand,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_opcode,
        input  instr_operand,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit_pc.sv
// Program counter: redirect load takes priority over increment; the
// increment wraps modulo 2^ADDR_W.
module fetch_pc #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + PC_STEP;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// 8sc fetch front end: IDLE -> FETCH -> WAIT -> ISSUE loop over synchronous
// program memory, with branch redirects squashing any in-flight fetch.
module instr_fetch_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int OPC_W  = fetch_pkg::OPC_W,
    parameter int OPR_W  = fetch_pkg::OPR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    instr_fetch_unit_if.master instr,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy
);
    import fetch_pkg::*;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [OPC_W-1:0]  opcode_q;
    logic [OPR_W-1:0]  operand_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              pc_inc;

    // A redirect during WAIT wins over the increment, so the squashed word
    // never advances the counter.
    assign pc_inc = (state == ST_WAIT) && !redirect;

    fetch_pc #(.ADDR_W(ADDR_W)) u_fetch_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect),
        .load_pc (redirect_pc),
        .inc     (pc_inc),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            opcode_q   <= '0;
            operand_q  <= '0;
            instr_pc_q <= '0;
        end else if (redirect) begin
            state <= run ? ST_FETCH : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    opcode_q   <= imem_rdata[DATA_W-1 -: OPC_W];
                    operand_q  <= imem_rdata[OPR_W-1:0];
                    instr_pc_q <= pc;
                    state      <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (instr.instr_ready) state <= run ? ST_FETCH : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_rd             = (state == ST_FETCH);
    assign imem_addr           = pc;
    assign busy                = (state != ST_IDLE);
    assign instr.instr_valid   = (state == ST_ISSUE);
    assign instr.instr_opcode  = opcode_q;
    assign instr.instr_operand = operand_q;
    assign instr.instr_pc      = instr_pc_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run checked against a transaction-level program-order model.
module tb_instr_fetch_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       imem_rd;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata = 8'h00;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       busy;

    logic [7:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_unit_if #(.ADDR_W(8), .OPC_W(3), .OPR_W(5)) ifc ();

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .OPC_W(3), .OPR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (ifc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem[imem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.instr_ready = 1'b0;
        #3;
        n_tests++; if (imem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_imem_rd got %b exp 0", imem_rd); end
        n_tests++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_imem_addr got %h exp 00", imem_addr); end
        n_tests++; if (ifc.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", ifc.instr_valid); end
        n_tests++; if (ifc.instr_opcode !== 3'd0 || ifc.instr_operand !== 5'd0 || ifc.instr_pc !== 8'h00)
            begin n_fail++; $display("FAIL reset_fields got %0d/%0d/%h exp 0/0/00", ifc.instr_opcode, ifc.instr_operand, ifc.instr_pc); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [2:0] exp_opc [3];
        logic [4:0] exp_opr [3];
        exp_opc[0] = 3'd3; exp_opr[0] = 5'd1;
        exp_opc[1] = 3'd0; exp_opr[1] = 5'd10;
        exp_opc[2] = 3'd7; exp_opr[2] = 5'd3;
        mem[0] = 8'h61; mem[1] = 8'h0A; mem[2] = 8'hE3;
        run = 1'b1;
        ifc.instr_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            n_tests++; if (ifc.instr_valid !== (c % 3 == 0))
                begin n_fail++; $display("FAIL basic_valid c=%0d got %b exp %b", c, ifc.instr_valid, (c % 3 == 0)); end
            n_tests++; if (imem_rd !== (c % 3 == 1))
                begin n_fail++; $display("FAIL basic_imem_rd c=%0d got %b exp %b", c, imem_rd, (c % 3 == 1)); end
            if (c % 3 == 1) begin
                n_tests++; if (imem_addr !== 8'((c - 1) / 3))
                    begin n_fail++; $display("FAIL basic_addr c=%0d got %h exp %h", c, imem_addr, 8'((c - 1) / 3)); end
            end
            if (c % 3 == 0) begin
                n_tests++;
                if (ifc.instr_opcode !== exp_opc[c/3-1] || ifc.instr_operand !== exp_opr[c/3-1] || ifc.instr_pc !== 8'(c/3-1)) begin
                    n_fail++;
                    $display("FAIL basic_issue c=%0d got %0d/%0d/%h exp %0d/%0d/%h", c, ifc.instr_opcode,
                             ifc.instr_operand, ifc.instr_pc, exp_opc[c/3-1], exp_opr[c/3-1], 8'(c/3-1));
                end
            end
        end
        run = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle busy got %b exp 0", busy); end
    endtask

    task automatic test_stall();
        logic [7:0] w;
        w = mem[3];
        run = 1'b1;
        ifc.instr_ready = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (ifc.instr_valid !== 1'b1 || ifc.instr_pc !== 8'h03 || ifc.instr_opcode !== w[7:5] || ifc.instr_operand !== w[4:0]) begin
                n_fail++;
                $display("FAIL stall_hold i=%0d got v=%b %0d/%0d/%h exp v=1 %0d/%0d/03", i, ifc.instr_valid,
                         ifc.instr_opcode, ifc.instr_operand, ifc.instr_pc, w[7:5], w[4:0]);
            end
            n_tests++; if (imem_rd !== 1'b0 || imem_addr !== 8'h04)
                begin n_fail++; $display("FAIL stall_mem i=%0d got rd=%b addr=%h exp rd=0 addr=04", i, imem_rd, imem_addr); end
            tick();
        end
        ifc.instr_ready = 1'b1;
        run = 1'b0;
        tick();
        n_tests++; if (ifc.instr_valid !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL stall_release got v=%b busy=%b exp 0/0", ifc.instr_valid, busy); end
    endtask

    task automatic test_redirect_wait();
        logic [7:0] w;
        w = mem[8'h40];
        run = 1'b1;
        ifc.instr_ready = 1'b1;
        tick(); tick();
        redirect = 1'b1;
        redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        n_tests++; if (imem_rd !== 1'b1 || imem_addr !== 8'h40 || ifc.instr_valid !== 1'b0)
            begin n_fail++; $display("FAIL redir_wait_fetch got rd=%b addr=%h v=%b exp 1/40/0", imem_rd, imem_addr, ifc.instr_valid); end
        tick();
        n_tests++; if (ifc.instr_valid !== 1'b0)
            begin n_fail++; $display("FAIL redir_wait_squash got v=%b exp 0", ifc.instr_valid); end
        tick();
        n_tests++;
        if (ifc.instr_valid !== 1'b1 || ifc.instr_pc !== 8'h40 || ifc.instr_opcode !== w[7:5] || ifc.instr_operand !== w[4:0]) begin
            n_fail++;
            $display("FAIL redir_wait_issue got v=%b %0d/%0d/%h exp v=1 %0d/%0d/40", ifc.instr_valid,
                     ifc.instr_opcode, ifc.instr_operand, ifc.instr_pc, w[7:5], w[4:0]);
        end
        run = 1'b0;
        tick();
    endtask

    task automatic test_redirect_hs();
        logic [7:0] w;
        w = mem[8'h10];
        run = 1'b1;
        ifc.instr_ready = 1'b1;
        tick(); tick(); tick();
        n_tests++; if (ifc.instr_valid !== 1'b1 || ifc.instr_pc !== 8'h41)
            begin n_fail++; $display("FAIL redir_hs_pre got v=%b pc=%h exp 1/41", ifc.instr_valid, ifc.instr_pc); end
        redirect = 1'b1;
        redirect_pc = 8'h10;
        tick();
        redirect = 1'b0;
        n_tests++; if (ifc.instr_valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 8'h10)
            begin n_fail++; $display("FAIL redir_hs_fetch got v=%b rd=%b addr=%h exp 0/1/10", ifc.instr_valid, imem_rd, imem_addr); end
        run = 1'b0;
        tick(); tick();
        n_tests++;
        if (ifc.instr_valid !== 1'b1 || ifc.instr_pc !== 8'h10 || ifc.instr_opcode !== w[7:5] || ifc.instr_operand !== w[4:0]) begin
            n_fail++;
            $display("FAIL redir_hs_issue got v=%b %0d/%0d/%h exp v=1 %0d/%0d/10", ifc.instr_valid,
                     ifc.instr_opcode, ifc.instr_operand, ifc.instr_pc, w[7:5], w[4:0]);
        end
        tick();
        n_tests++; if (busy !== 1'b0)
            begin n_fail++; $display("FAIL redir_hs_idle busy got %b exp 0", busy); end
    endtask

    task automatic test_wrap();
        logic [7:0] w;
        w = mem[8'hFF];
        run = 1'b0;
        redirect = 1'b1;
        redirect_pc = 8'hFF;
        tick();
        redirect = 1'b0;
        n_tests++; if (busy !== 1'b0 || imem_addr !== 8'hFF)
            begin n_fail++; $display("FAIL wrap_idle_load got busy=%b addr=%h exp 0/ff", busy, imem_addr); end
        run = 1'b1;
        ifc.instr_ready = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if (ifc.instr_valid !== 1'b1 || ifc.instr_pc !== 8'hFF || ifc.instr_opcode !== w[7:5] || ifc.instr_operand !== w[4:0]) begin
            n_fail++;
            $display("FAIL wrap_issue got v=%b %0d/%0d/%h exp v=1 %0d/%0d/ff", ifc.instr_valid,
                     ifc.instr_opcode, ifc.instr_operand, ifc.instr_pc, w[7:5], w[4:0]);
        end
        tick();
        n_tests++; if (imem_rd !== 1'b1 || imem_addr !== 8'h00)
            begin n_fail++; $display("FAIL wrap_next_addr got rd=%b addr=%h exp 1/00", imem_rd, imem_addr); end
        run = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_run_drop();
        run = 1'b1;
        ifc.instr_ready = 1'b1;
        tick();
        run = 1'b0;
        tick(); tick();
        n_tests++; if (ifc.instr_valid !== 1'b1 || ifc.instr_pc !== 8'h01)
            begin n_fail++; $display("FAIL run_drop_issue got v=%b pc=%h exp 1/01", ifc.instr_valid, ifc.instr_pc); end
        tick();
        n_tests++; if (busy !== 1'b0 || ifc.instr_valid !== 1'b0)
            begin n_fail++; $display("FAIL run_drop_idle got busy=%b v=%b exp 0/0", busy, ifc.instr_valid); end
    endtask

    task automatic test_reset_mid();
        run = 1'b1;
        tick(); tick();
        n_tests++; if (busy !== 1'b1 || imem_addr !== 8'h02)
            begin n_fail++; $display("FAIL rst_mid_pre got busy=%b addr=%h exp 1/02", busy, imem_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (imem_rd !== 1'b0 || imem_addr !== 8'h00 || ifc.instr_valid !== 1'b0 || ifc.instr_opcode !== 3'd0 ||
            ifc.instr_operand !== 5'd0 || ifc.instr_pc !== 8'h00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async got rd=%b addr=%h v=%b %0d/%0d/%h busy=%b exp all zero", imem_rd, imem_addr,
                     ifc.instr_valid, ifc.instr_opcode, ifc.instr_operand, ifc.instr_pc, busy);
        end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Model: accepted instructions follow program order from the last
    // redirect target; only handshakes are compared.
    task automatic test_random();
        logic [7:0] exp_next;
        logic [7:0] w;
        logic       hs;
        int         n_hs;
        exp_next = 8'h00;
        n_hs = 0;
        run = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            ifc.instr_ready = 1'($urandom_range(0, 1));
            redirect = ($urandom_range(0, 9) == 0);
            redirect_pc = 8'($urandom);
            hs = ifc.instr_valid && ifc.instr_ready;
            if (hs) begin
                n_hs++;
                w = mem[exp_next];
                n_tests++;
                if (ifc.instr_pc !== exp_next || ifc.instr_opcode !== w[7:5] || ifc.instr_operand !== w[4:0]) begin
                    n_fail++;
                    $display("FAIL rand_issue i=%0d got %0d/%0d/%h exp %0d/%0d/%h", i, ifc.instr_opcode,
                             ifc.instr_operand, ifc.instr_pc, w[7:5], w[4:0], exp_next);
                end
            end
            if (redirect) exp_next = redirect_pc;
            else if (hs) exp_next = exp_next + 8'h01;
            tick();
        end
        redirect = 1'b0;
        run = 1'b0;
        n_tests++; if (n_hs < 50)
            begin n_fail++; $display("FAIL rand_progress got %0d handshakes exp at least 50", n_hs); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_hs();
        test_wrap();
        test_run_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
